// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encodings and divider helper for the UART
package uart_pkg;

    localparam int PAR_NONE   = 0;
    localparam int PAR_EVEN   = 1;
    localparam int PAR_ODD    = 2;
    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        RXS_IDLE,
        RXS_START,
        RXS_DATA,
        RXS_PARITY,
        RXS_STOP,
        RXS_BRK
    } rx_state_t;

    typedef enum logic [2:0] {
        TXS_IDLE,
        TXS_START,
        TXS_DATA,
        TXS_PARITY,
        TXS_STOP
    } tx_state_t;

    // Rounded divider; never below 1 so the tick generator stays legal.
    function automatic int calc_div(input int clk_freq, input int baud);
        int d;
        d = (clk_freq + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - free-running divider emitting one tick every DIV clocks
module uart_baud_gen #(
    parameter int DIV = 27
) (
    input  logic CLK,
    input  logic RST,
    output logic TICK
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign TICK = (cnt == LAST);

endmodule

// File: rtl/uart_param.sv
// rtl/uart_param.sv - UART with configurable data width, parity and stop bits
module uart_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    input  logic       TX_START,
    input  logic [7:0] TX_DATA,
    output logic       TX,
    output logic       TX_BUSY,
    output logic       TX_DONE,
    output logic [7:0] RX_DATA,
    output logic       RX_DONE,
    output logic       RX_PERR,
    output logic       RX_FERR
);

    localparam int         DIV        = calc_div(CLK_FREQ, BAUD);
    localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);
    localparam logic [4:0] STOP_LAST  = 5'(OVERSAMPLE * STOP_BITS - 1);
    localparam logic [7:0] DATA_MASK  = 8'((1 << DATA_BITS) - 1);
    localparam logic       HAS_PARITY = (PARITY != PAR_NONE);
    localparam logic       ODD_PARITY = (PARITY == PAR_ODD);

    logic tick;

    uart_baud_gen #(.DIV(DIV)) u_baud (
        .CLK  (CLK),
        .RST  (RST),
        .TICK (tick)
    );

    logic [1:0] rx_sync;
    logic       rx_s;
    rx_state_t  rx_state;
    logic [3:0] rx_cnt;
    logic [2:0] rx_bit;
    logic [7:0] rx_shreg;
    logic       rx_par_err;

    assign rx_s = rx_sync[1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_sync    <= 2'b11;
            rx_state   <= RXS_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shreg   <= '0;
            rx_par_err <= 1'b0;
            RX_DATA    <= '0;
            RX_PERR    <= 1'b0;
            RX_FERR    <= 1'b0;
            RX_DONE    <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], RX};
            RX_DONE <= 1'b0;
            case (rx_state)
                RXS_IDLE: begin
                    if (!rx_s) begin
                        rx_state <= RXS_START;
                        rx_cnt   <= '0;
                    end
                end
                RXS_START: begin
                    if (tick) begin
                        if (rx_cnt == 4'd7) begin
                            // Mid-start-bit check rejects glitches shorter than half a bit.
                            rx_cnt <= '0;
                            if (rx_s) begin
                                rx_state <= RXS_IDLE;
                            end else begin
                                rx_state   <= RXS_DATA;
                                rx_bit     <= '0;
                                rx_shreg   <= '0;
                                rx_par_err <= 1'b0;
                            end
                        end else begin
                            rx_cnt <= rx_cnt + 4'd1;
                        end
                    end
                end
                RXS_DATA: begin
                    if (tick) begin
                        rx_cnt <= rx_cnt + 4'd1;
                        if (rx_cnt == 4'd15) begin
                            rx_shreg[rx_bit] <= rx_s;
                            rx_bit           <= rx_bit + 3'd1;
                            if (rx_bit == LAST_BIT) begin
                                rx_state <= HAS_PARITY ? RXS_PARITY : RXS_STOP;
                            end
                        end
                    end
                end
                RXS_PARITY: begin
                    if (tick) begin
                        rx_cnt <= rx_cnt + 4'd1;
                        if (rx_cnt == 4'd15) begin
                            rx_par_err <= rx_s ^ (^rx_shreg) ^ ODD_PARITY;
                            rx_state   <= RXS_STOP;
                        end
                    end
                end
                RXS_STOP: begin
                    if (tick) begin
                        rx_cnt <= rx_cnt + 4'd1;
                        if (rx_cnt == 4'd15) begin
                            RX_DATA  <= rx_shreg;
                            RX_PERR  <= rx_par_err;
                            RX_FERR  <= ~rx_s;
                            RX_DONE  <= 1'b1;
                            rx_state <= rx_s ? RXS_IDLE : RXS_BRK;
                        end
                    end
                end
                RXS_BRK: begin
                    // A held-low line must not be mistaken for a stream of start bits.
                    if (rx_s) begin
                        rx_state <= RXS_IDLE;
                    end
                end
                default: rx_state <= RXS_IDLE;
            endcase
        end
    end

    tx_state_t  tx_state;
    logic [4:0] tx_cnt;
    logic [2:0] tx_bit;
    logic [7:0] tx_shreg;
    logic       tx_par;

    assign TX_BUSY = (tx_state != TXS_IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tx_state <= TXS_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
            tx_par   <= 1'b0;
            TX       <= 1'b1;
            TX_DONE  <= 1'b0;
        end else begin
            TX_DONE <= 1'b0;
            case (tx_state)
                TXS_IDLE: begin
                    if (TX_START) begin
                        tx_shreg <= TX_DATA & DATA_MASK;
                        tx_par   <= (^(TX_DATA & DATA_MASK)) ^ ODD_PARITY;
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        TX       <= 1'b0;
                        tx_state <= TXS_START;
                    end
                end
                TXS_START: begin
                    if (tick) begin
                        if (tx_cnt == 5'd15) begin
                            tx_cnt   <= '0;
                            TX       <= tx_shreg[0];
                            tx_state <= TXS_DATA;
                        end else begin
                            tx_cnt <= tx_cnt + 5'd1;
                        end
                    end
                end
                TXS_DATA: begin
                    if (tick) begin
                        if (tx_cnt == 5'd15) begin
                            tx_cnt <= '0;
                            if (tx_bit == LAST_BIT) begin
                                TX       <= HAS_PARITY ? tx_par : 1'b1;
                                tx_state <= HAS_PARITY ? TXS_PARITY : TXS_STOP;
                            end else begin
                                tx_bit   <= tx_bit + 3'd1;
                                tx_shreg <= tx_shreg >> 1;
                                TX       <= tx_shreg[1];
                            end
                        end else begin
                            tx_cnt <= tx_cnt + 5'd1;
                        end
                    end
                end
                TXS_PARITY: begin
                    if (tick) begin
                        if (tx_cnt == 5'd15) begin
                            tx_cnt   <= '0;
                            TX       <= 1'b1;
                            tx_state <= TXS_STOP;
                        end else begin
                            tx_cnt <= tx_cnt + 5'd1;
                        end
                    end
                end
                TXS_STOP: begin
                    if (tick) begin
                        if (tx_cnt == STOP_LAST) begin
                            tx_cnt   <= '0;
                            TX_DONE  <= 1'b1;
                            tx_state <= TXS_IDLE;
                        end else begin
                            tx_cnt <= tx_cnt + 5'd1;
                        end
                    end
                end
                default: tx_state <= TXS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_param.sv
// tb/tb_uart_param.sv - scoreboard bench for uart_param in three frame formats
module tb_uart_param;

    localparam int P_BIT = 64;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    exp_t q_a[$];
    exp_t q_p[$];
    exp_t q_b[$];

    logic       a_tx_start = 1'b0, p_tx_start = 1'b0, b_tx_start = 1'b0;
    logic [7:0] a_tx_data = '0, p_tx_data = '0, b_tx_data = '0;
    logic       a_tx, a_tx_busy, a_tx_done, a_rx_done, a_rx_perr, a_rx_ferr;
    logic       p_tx, p_tx_busy, p_tx_done, p_rx_done, p_rx_perr, p_rx_ferr;
    logic       b_tx, b_tx_busy, b_tx_done, b_rx_done, b_rx_perr, b_rx_ferr;
    logic [7:0] a_rx_data, p_rx_data, b_rx_data;
    logic       p_loop = 1'b1;
    logic       drv = 1'b1;
    logic       p_rx;

    assign p_rx = p_loop ? p_tx : drv;

    uart_param dut_a (
        .CLK(CLK), .RST(RST), .RX(a_tx), .TX_START(a_tx_start), .TX_DATA(a_tx_data),
        .TX(a_tx), .TX_BUSY(a_tx_busy), .TX_DONE(a_tx_done), .RX_DATA(a_rx_data),
        .RX_DONE(a_rx_done), .RX_PERR(a_rx_perr), .RX_FERR(a_rx_ferr)
    );

    uart_param #(.CLK_FREQ(7_372_800), .BAUD(115_200), .PARITY(1)) dut_p (
        .CLK(CLK), .RST(RST), .RX(p_rx), .TX_START(p_tx_start), .TX_DATA(p_tx_data),
        .TX(p_tx), .TX_BUSY(p_tx_busy), .TX_DONE(p_tx_done), .RX_DATA(p_rx_data),
        .RX_DONE(p_rx_done), .RX_PERR(p_rx_perr), .RX_FERR(p_rx_ferr)
    );

    uart_param #(.CLK_FREQ(7_372_800), .BAUD(115_200), .DATA_BITS(5), .STOP_BITS(2)) dut_b (
        .CLK(CLK), .RST(RST), .RX(b_tx), .TX_START(b_tx_start), .TX_DATA(b_tx_data),
        .TX(b_tx), .TX_BUSY(b_tx_busy), .TX_DONE(b_tx_done), .RX_DATA(b_rx_data),
        .RX_DONE(b_rx_done), .RX_PERR(b_rx_perr), .RX_FERR(b_rx_ferr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic int qsize(input int which);
        case (which)
            0: return q_a.size();
            1: return q_p.size();
            default: return q_b.size();
        endcase
    endfunction

    function automatic exp_t qpop(input int which);
        case (which)
            0: return q_a.pop_front();
            1: return q_p.pop_front();
            default: return q_b.pop_front();
        endcase
    endfunction

    task automatic mon(input int which, input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        if (qsize(which) == 0) begin
            total++;
            bad++;
            $display("FAIL rx_unexpected_%0d: got data=%0h perr=%0b ferr=%0b expected no frame",
                     which, d, pe, fe);
        end else begin
            e = qpop(which);
            check($sformatf("rx_data_%0d", which), 32'(d), 32'(e.data));
            check($sformatf("rx_perr_%0d", which), 32'(pe), 32'(e.perr));
            check($sformatf("rx_ferr_%0d", which), 32'(fe), 32'(e.ferr));
        end
    endtask

    // Monitor: every RX_DONE is matched against the oldest expected frame of that instance.
    always @(negedge CLK) begin
        if (a_rx_done) mon(0, a_rx_data, a_rx_perr, a_rx_ferr);
        if (p_rx_done) mon(1, p_rx_data, p_rx_perr, p_rx_ferr);
        if (b_rx_done) mon(2, b_rx_data, b_rx_perr, b_rx_ferr);
    end

    task automatic wait_empty(input int which, input int budget);
        int n = 0;
        while (qsize(which) != 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check($sformatf("drain_%0d", which), 32'(qsize(which)), 32'd0);
    endtask

    task automatic p_frame(input logic [7:0] d, input logic par, input logic stop);
        logic [10:0] bits;
        bits = {stop, par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            drv = bits[i];
            repeat (P_BIT) @(negedge CLK);
        end
    endtask

    task automatic check_a_reset(input string tag);
        check({tag, "_tx"},      32'(a_tx), 32'd1);
        check({tag, "_busy"},    32'(a_tx_busy), 32'd0);
        check({tag, "_txdone"},  32'(a_tx_done), 32'd0);
        check({tag, "_rxdone"},  32'(a_rx_done), 32'd0);
        check({tag, "_rxdata"},  32'(a_rx_data), 32'd0);
        check({tag, "_perr"},    32'(a_rx_perr), 32'd0);
        check({tag, "_ferr"},    32'(a_rx_ferr), 32'd0);
    endtask

    initial begin
        int n;
        int h;
        logic low_seen;

        repeat (3) @(negedge CLK);
        check_a_reset("reset");
        check("reset_b_tx", 32'(b_tx), 32'd1);
        RST = 1'b0;
        repeat (5) @(negedge CLK);

        // 8N1 loopback of 0xA5 and frame duration
        q_a.push_back('{8'hA5, 1'b0, 1'b0});
        a_tx_data = 8'hA5;
        a_tx_start = 1'b1;
        @(negedge CLK);
        a_tx_start = 1'b0;
        check("a_tx_low", 32'(a_tx), 32'd0);
        check("a_busy", 32'(a_tx_busy), 32'd1);
        n = 0;
        while (!a_tx_done && n < 6000) begin
            @(negedge CLK);
            n++;
        end
        check_range("a_frame_cycles", n, 4320 - 27, 4320 + 27);
        check("a_busy_at_done", 32'(a_tx_busy), 32'd0);
        wait_empty(0, 500);

        // Even parity: transmitted parity bit of 0x07 is 1, loopback clean
        q_p.push_back('{8'h07, 1'b0, 1'b0});
        p_tx_data = 8'h07;
        p_tx_start = 1'b1;
        @(negedge CLK);
        p_tx_start = 1'b0;
        repeat (604) @(negedge CLK);
        check("p_parity_bit", 32'(p_tx), 32'd1);
        n = 0;
        while (!p_tx_done && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        check("p_done_seen", 32'(p_tx_done), 32'd1);
        wait_empty(1, 200);

        // Flipped parity bit on the wire
        p_loop = 1'b0;
        drv = 1'b1;
        repeat (P_BIT) @(negedge CLK);
        q_p.push_back('{8'h07, 1'b1, 1'b0});
        p_frame(8'h07, 1'b0, 1'b1);
        drv = 1'b1;
        repeat (P_BIT) @(negedge CLK);
        wait_empty(1, 200);

        // Stop bit 0 followed by a 40-bit break, then a valid frame
        q_p.push_back('{8'h81, 1'b0, 1'b1});
        p_frame(8'h81, 1'b0, 1'b0);
        repeat (40 * P_BIT) @(negedge CLK);
        check("p_break_drained", 32'(q_p.size()), 32'd0);
        drv = 1'b1;
        repeat (2 * P_BIT) @(negedge CLK);
        q_p.push_back('{8'h3C, 1'b0, 1'b0});
        p_frame(8'h3C, 1'b0, 1'b1);
        drv = 1'b1;
        repeat (P_BIT) @(negedge CLK);
        wait_empty(1, 200);

        // 4-tick glitch is a false start; next frame still received
        drv = 1'b0;
        repeat (16) @(negedge CLK);
        drv = 1'b1;
        repeat (3 * P_BIT) @(negedge CLK);
        q_p.push_back('{8'h5A, 1'b0, 1'b0});
        p_frame(8'h5A, 1'b0, 1'b1);
        drv = 1'b1;
        repeat (P_BIT) @(negedge CLK);
        wait_empty(1, 200);

        // 5N2: all-ones word, ignored mid-frame start, back-to-back start on TX_DONE
        q_b.push_back('{8'h1F, 1'b0, 1'b0});
        b_tx_data = 8'hFF;
        b_tx_start = 1'b1;
        @(negedge CLK);
        b_tx_start = 1'b0;
        b_tx_data = 8'h00;
        n = 0;
        while (b_tx == 1'b0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check_range("b_start_cycles", n, 61, 64);
        h = 0;
        low_seen = 1'b0;
        while (!b_tx_done && h < 1000) begin
            b_tx_start = (h == 100);
            @(negedge CLK);
            h++;
            if (!b_tx) low_seen = 1'b1;
        end
        b_tx_start = 1'b0;
        check("b_high_cycles", 32'(h), 32'd448);
        check("b_no_low_in_frame", 32'(low_seen), 32'd0);
        check("b_busy_at_done", 32'(b_tx_busy), 32'd0);
        q_b.push_back('{8'h0A, 1'b0, 1'b0});
        b_tx_data = 8'h0A;
        b_tx_start = 1'b1;
        @(negedge CLK);
        b_tx_start = 1'b0;
        check("b_b2b_tx_low", 32'(b_tx), 32'd0);
        check("b_b2b_busy", 32'(b_tx_busy), 32'd1);
        n = 0;
        while (!b_tx_done && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        check("b_second_done", 32'(b_tx_done), 32'd1);
        wait_empty(2, 200);
        repeat (100) @(negedge CLK);
        check("b_idle_after", 32'(b_tx_busy), 32'd0);

        // Reset mid-frame on both TX and RX of the loopback instance
        a_tx_data = 8'hC3;
        a_tx_start = 1'b1;
        @(negedge CLK);
        a_tx_start = 1'b0;
        repeat (1928) @(negedge CLK);
        check("a_mid_busy", 32'(a_tx_busy), 32'd1);
        #1 RST = 1'b1;
        #1;
        check_a_reset("midrst");
        check("midrst_p_rxdata", 32'(p_rx_data), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (10) @(negedge CLK);
        q_a.push_back('{8'h55, 1'b0, 1'b0});
        a_tx_data = 8'h55;
        a_tx_start = 1'b1;
        @(negedge CLK);
        a_tx_start = 1'b0;
        n = 0;
        while (!a_tx_done && n < 6000) begin
            @(negedge CLK);
            n++;
        end
        check("a_post_rst_done", 32'(a_tx_done), 32'd1);
        wait_empty(0, 500);
        check("final_q_p", 32'(q_p.size()), 32'd0);
        check("final_q_b", 32'(q_b.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
